// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter: the counter sits on the slave side,
// the block driving enable/direction/clear/load sits on the master side.
interface mod_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] out;
   logic             tc;
   logic             ovf;

   modport master (
      output en, up, clr, load, load_val,
      input  out, tc, ovf
   );

   modport slave (
      input  en, up, clr, load, load_val,
      output out, tc, ovf
   );
endinterface

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter (range 0..MAX) with enable, synchronous
// clear, clamped parallel load, wrap or saturate at the boundaries, a
// combinational terminal-count flag and a registered one-cycle overflow pulse.
// Legal configurations: WIDTH >= 1, 1 <= MAX <= 2**WIDTH-1.
module mod_counter #(
   parameter int WIDTH    = 4,
   parameter int MAX      = 15,
   parameter int SATURATE = 0
) (
   input  logic         clk,
   input  logic         rst,
   mod_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
   localparam bit               SAT_B  = (SATURATE != 0);

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             tc_s;

   // Next-state: clr > load > count > hold; boundaries are detected against
   // MAX explicitly so the range is 0..MAX, not the natural 2**WIDTH rollover.
   always_comb begin
      out_d = out_q;
      ovf_d = 1'b0;
      if (bus.clr) begin
         out_d = ZERO_V;
      end else if (bus.load) begin
         if (bus.load_val > MAX_V) begin
            out_d = MAX_V;
         end else begin
            out_d = bus.load_val;
         end
      end else if (bus.en) begin
         if (bus.up) begin
            // A value above MAX can only come from external forcing; treat it
            // as sitting on the upper boundary so it recovers into range.
            if (out_q >= MAX_V) begin
               ovf_d = 1'b1;
               out_d = SAT_B ? MAX_V : ZERO_V;
            end else begin
               out_d = out_q + ONE_V;
            end
         end else begin
            if (out_q == ZERO_V) begin
               ovf_d = 1'b1;
               out_d = SAT_B ? ZERO_V : MAX_V;
            end else if (out_q > MAX_V) begin
               out_d = MAX_V;
            end else begin
               out_d = out_q - ONE_V;
            end
         end
      end else begin
         out_d = out_q;
      end
   end

   // Count and overflow registers; reset acts asynchronously and holds state at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= ZERO_V;
         ovf_q <= 1'b0;
      end else begin
         out_q <= out_d;
         ovf_q <= ovf_d;
      end
   end

   // Terminal count follows direction with no register stage.
   always_comb begin
      if (bus.up) begin
         tc_s = (out_q == MAX_V);
      end else begin
         tc_s = (out_q == ZERO_V);
      end
   end

   assign bus.out = out_q;
   assign bus.ovf = ovf_q;
   assign bus.tc  = tc_s;

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised up/down modulo counter, the next-generation replacement for the fixed 4-bit free-running counter. Adds configurable width and modulus, direction control, count enable, synchronous clear and parallel load, wrap or saturate mode, and terminal-count and overflow flags. It is a standalone sequential block used for timers, event counting and address generation inside the class designs.

## Interface

- `WIDTH`, default 4: counter width in bits; must be at least 1.
- `MAX`, default 15: terminal (highest) count value; counter range is 0..MAX; must satisfy 1 ≤ MAX ≤ 2^WIDTH−1.
- `SATURATE`, default 0: 0 = wrap at the boundaries, 1 = hold at the boundaries.

- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  count enable.
- `up`  input  1  direction: 1 = increment, 0 = decrement.
- `clr`  input  1  synchronous clear to 0.
- `load`  input  1  synchronous parallel load.
- `load_val`  input  WIDTH  value captured on `load`.
- `out`  output  WIDTH  current count, registered.
- `tc`  output  1  terminal count, combinational: `out == MAX` when `up` = 1, or `out == 0` when `up` = 0.
- `ovf`  output  1  registered one-cycle pulse marking a boundary crossing attempt.

## Operation

- Priority, highest first: `rst` > `clr` > `load` > `en` count > hold.
- `rst` asserted:
  - `out` = 0 and `ovf` = 0 immediately, independent of `clk`.
  - State is held while `rst` is high.
  - Release is clean: the first count happens at the first rising edge on which `rst` = 0 and `en` = 1.
- `clr` = 1: `out` ← 0 and `ovf` ← 0, regardless of `load` or `en`.
- `load` = 1 with `clr` = 0:
  - `out` ← `load_val` when `load_val` ≤ MAX; otherwise `out` ← MAX (clamped).
  - `ovf` ← 0.
  - `en` is ignored in that cycle.
- Counting, when `en` = 1 and neither `clr` nor `load` is active:
  - Up, `out` < MAX: `out` ← `out`+1.
  - Up, `out` == MAX: `out` ← 0 if SATURATE = 0, else `out` stays MAX. `ovf` ← 1 in both modes.
  - Down, `out` > 0: `out` ← `out`−1.
  - Down, `out` == 0: `out` ← MAX if SATURATE = 0, else `out` stays 0. `ovf` ← 1 in both modes.
- `en` = 0 with no `clr` or `load`: `out` holds and `ovf` ← 0.
- `ovf` is therefore high for exactly the one cycle after each boundary-crossing edge.
  - In saturate mode it re-asserts on every enabled edge while the counter is pinned at the boundary.
- Arithmetic is modulo MAX+1, not modulo 2^WIDTH.
  - `out` never takes a value above MAX, except transiently if `out` was forced externally; this does not happen in normal operation.
  - The next-state logic compares `out` against MAX, never relying on natural WIDTH rollover.
- `up` may change on any cycle; the new direction takes effect at the next edge.
  - `tc` follows `up` combinationally.

## Timing

- Latency from `en`/`up`/`clr`/`load` sampled at edge N to the updated `out`: visible after edge N (one register stage).
- `ovf` is registered alongside `out`: it is high during the cycle after the wrapping edge, coincident with the wrapped `out` value.
- `tc` has zero latency from `out` and `up`. A terminal-count detect asserts `tc` one cycle before the wrap, and `ovf` one cycle after it.
- Reset assertion takes effect asynchronously. Deassertion is synchronised by the user; no internal reset synchroniser.

## Test plan

1. Defaults, `rst` high for 20 ns, then `en` = 1, `up` = 1 for 20 cycles:
   - `out` runs 0..15, then 0..3.
   - `tc` = 1 while `out` = 15.
   - `ovf` = 1 for exactly one cycle, when `out` = 0 after the wrap.
2. MAX = 9, `up` = 0 from reset:
   - `out` sequence is 0→9→8…→0→9.
   - `ovf` pulses on each 0→9 transition.
   - `out` never exceeds 9.
3. SATURATE = 1, MAX = 5, count up for 8 edges:
   - `out` = 0,1,2,3,4,5,5,5.
   - `ovf` is high on the 2 cycles where `out` is held at 5 after overflow.
   - Then `up` = 0: `out` goes 4,3…
4. Load and clamp:
   - `load` with `load_val` = 7 → `out` = 7 after one edge.
   - MAX = 9, `load_val` = 13 → `out` = 9.
   - `load` together with `en` = 1 → the load wins; no count that cycle.
5. Priority and reset mid-count:
   - Count to 6, then assert `clr` and `load` (`load_val` = 3) together → `out` = 0.
   - Count again, then pulse `rst` between clock edges → `out` = 0 immediately, without an edge.
   - After release, `en` = 1 → `out` = 1 after the first edge.
6. `en` gating and direction flip:
   - With `out` = 4, drop `en` for 3 cycles → `out` holds at 4 and `ovf` = 0.
   - Then alternate `up` every cycle with `en` = 1 → `out` = 5,4,5,4.
